// File: rtl/dat_fill_sequencer.sv
// DAT RAM bulk fill engine and single-port arbiter; the CPU always wins the port.
// Optional DAT_AUTO_INIT_EN: identity-fill entries 0..7 automatically after reset.
module dat_fill_sequencer #(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned DATA_W = 16
) (
  input  logic              e,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   count,
  input  logic [DATA_W-1:0] fill_val,
  input  logic              fill_inc,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_we_l,
  input  logic              cpu_we_h,
  output logic [ADDR_W-1:0] dat_addr,
  output logic [DATA_W-1:0] dat_wdata,
  output logic              dat_we_l,
  output logic              dat_we_h,
  output logic              busy,
  output logic              done,
  output logic [7:0]        stall_cnt
);

  typedef enum logic [1:0] {StIdle, StFill, StFinish} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] val_q, val_d;
  logic              inc_q, inc_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [7:0]        stall_q, stall_d;
  logic              launch;
  logic [ADDR_W-1:0] launch_addr;
  logic [ADDR_W:0]   launch_cnt;
  logic [DATA_W-1:0] launch_val;
  logic              launch_inc;
  logic              engine_own;

`ifdef DAT_AUTO_INIT_EN
  logic auto_q, auto_d;

  // A pending auto-init takes the place of a software start on the first idle cycle.
  always_comb begin
    auto_d = auto_q;
    if (state_q == StIdle && auto_q) begin
      auto_d = 1'b0;
    end
    launch      = auto_q | start;
    launch_addr = auto_q ? '0 : start_addr;
    launch_cnt  = auto_q ? (ADDR_W+1)'(8) : count;
    launch_val  = auto_q ? '0 : fill_val;
    launch_inc  = auto_q ? 1'b1 : fill_inc;
  end

  always_ff @(posedge e or posedge reset) begin
    if (reset) begin
      auto_q <= 1'b1;
    end else begin
      auto_q <= auto_d;
    end
  end
`else
  always_comb begin
    launch      = start;
    launch_addr = start_addr;
    launch_cnt  = count;
    launch_val  = fill_val;
    launch_inc  = fill_inc;
  end
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    val_d   = val_q;
    inc_d   = inc_q;
    rem_d   = rem_q;
    stall_d = stall_q;
    unique case (state_q)
      StIdle: begin
        if (launch) begin
          addr_d  = launch_addr;
          val_d   = launch_val;
          inc_d   = launch_inc;
          rem_d   = launch_cnt;
          stall_d = 8'd0;
          state_d = (launch_cnt == '0) ? StFinish : StFill;
        end
      end
      StFill: begin
        if (cpu_req) begin
          if (stall_q != 8'hFF) begin
            stall_d = stall_q + 8'd1;
          end
        end else begin
          // Address wraps naturally at the top of the RAM.
          addr_d = addr_q + 1'b1;
          val_d  = val_q + DATA_W'(inc_q);
          rem_d  = rem_q - 1'b1;
          if (rem_q == (ADDR_W+1)'(1)) begin
            state_d = StFinish;
          end
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    busy_d = (state_d == StFill);
    done_d = (state_q == StFinish);
  end

  always_ff @(posedge e or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      val_q   <= '0;
      inc_q   <= 1'b0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      stall_q <= 8'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      val_q   <= val_d;
      inc_q   <= inc_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      stall_q <= stall_d;
    end
  end

  // Enables follow state asynchronously so a reset drops them immediately.
  assign engine_own = (state_q == StFill) && !cpu_req;
  assign dat_addr   = engine_own ? addr_q : cpu_addr;
  assign dat_wdata  = engine_own ? val_q : cpu_wdata;
  assign dat_we_l   = engine_own ? 1'b1 : cpu_we_l;
  assign dat_we_h   = engine_own ? 1'b1 : cpu_we_h;
  assign busy       = busy_q;
  assign done       = done_q;
  assign stall_cnt  = stall_q;

endmodule

// File: tb/tb_dat_fill_sequencer.sv
// Scoreboard bench for dat_fill_sequencer: expected DAT writes are queued at launch and
// popped as write enables appear on the port.
module tb_dat_fill_sequencer;

  logic        e = 1'b0;
  logic        reset;
  logic        start;
  logic [14:0] start_addr;
  logic [15:0] count;
  logic [15:0] fill_val;
  logic        fill_inc;
  logic        cpu_req;
  logic [14:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_we_l;
  logic        cpu_we_h;
  logic [14:0] dat_addr;
  logic [15:0] dat_wdata;
  logic        dat_we_l;
  logic        dat_we_h;
  logic        busy;
  logic        done;
  logic [7:0]  stall_cnt;

  typedef struct {
    logic [14:0] a;
    logic [15:0] d;
    int          c;
  } wr_t;

  wr_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;

  always #5 e = ~e;

  dat_fill_sequencer #(.ADDR_W(15), .DATA_W(16)) dut (
    .e(e), .reset(reset), .start(start), .start_addr(start_addr), .count(count),
    .fill_val(fill_val), .fill_inc(fill_inc), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_we_l(cpu_we_l), .cpu_we_h(cpu_we_h), .dat_addr(dat_addr),
    .dat_wdata(dat_wdata), .dat_we_l(dat_we_l), .dat_we_h(dat_we_h), .busy(busy),
    .done(done), .stall_cnt(stall_cnt)
  );

  // Queue the writes a fill should produce; entries landing at or after stall cycle s0
  // are pushed back by slen cycles.
  task automatic push_fill(input logic [14:0] sa, input int cnt, input logic [15:0] fv,
                           input logic inc, input int s0, input int slen);
    wr_t w;
    for (int i = 0; i < cnt; i++) begin
      w.a = sa + 15'(i);
      w.d = fv + (inc ? 16'(i) : 16'd0);
      w.c = (1 + i >= s0) ? 1 + i + slen : 1 + i;
      exp_q.push_back(w);
    end
  endtask

  // Present a start request sampled on the next rising edge; returns in cycle 1.
  task automatic launch(input logic [14:0] sa, input logic [15:0] cnt, input logic [15:0] fv,
                        input logic inc);
    @(negedge e);
    start = 1'b1; start_addr = sa; count = cnt; fill_val = fv; fill_inc = inc;
    @(posedge e);
    #1 start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; start_addr = '0; count = '0; fill_val = '0; fill_inc = 1'b0;
    cpu_req = 1'b0; cpu_addr = 15'h1234; cpu_wdata = 16'hBEEF; cpu_we_l = 1'b1; cpu_we_h = 1'b0;
    repeat (2) @(negedge e);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || stall_cnt !== 8'd0) begin
      failures++;
      $display("FAIL reset_state: busy=%b done=%b stall=%0d want 0 0 0", busy, done, stall_cnt);
    end
    checks++;
    if (dat_addr !== 15'h1234 || dat_wdata !== 16'hBEEF || dat_we_l !== 1'b1 || dat_we_h !== 1'b0) begin
      failures++;
      $display("FAIL idle_passthru: addr=%h data=%h we=%b%b want 1234 beef 01",
               dat_addr, dat_wdata, dat_we_h, dat_we_l);
    end
    cpu_we_l = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge e);
  endtask

  task automatic test_uncontested(input string name, input logic [14:0] sa, input int cnt,
                                  input logic [15:0] fv, input logic inc);
    wr_t w;
    int  done_cyc = -1;
    int  ndone = 0;
    push_fill(sa, cnt, fv, inc, 1 << 20, 0);
    launch(sa, 16'(cnt), fv, inc);
    for (int c = 1; c <= cnt + 5; c++) begin
      @(negedge e);
      if (dat_we_l || dat_we_h) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL %s_extra_write: got addr=%h data=%h cyc=%0d want none", name, dat_addr, dat_wdata, c);
        end else begin
          w = exp_q.pop_front();
          if (dat_addr !== w.a || dat_wdata !== w.d || c != w.c || {dat_we_h, dat_we_l} !== 2'b11) begin
            failures++;
            $display("FAIL %s_write: got addr=%h data=%h cyc=%0d we=%b%b want addr=%h data=%h cyc=%0d we=11",
                     name, dat_addr, dat_wdata, c, dat_we_h, dat_we_l, w.a, w.d, w.c);
          end
        end
      end
      if (c == 1) begin
        checks++;
        if (busy !== 1'b1) begin
          failures++;
          $display("FAIL %s_busy_rise: got %b want 1", name, busy);
        end
      end
      if (done) begin
        ndone++;
        if (done_cyc < 0) done_cyc = c;
      end
      @(posedge e);
      #1;
    end
    checks++;
    if (done_cyc != cnt + 2 || ndone != 1) begin
      failures++;
      $display("FAIL %s_done: got cyc=%0d pulses=%0d want cyc=%0d pulses=1", name, done_cyc, ndone, cnt + 2);
    end
    checks++;
    if (exp_q.size() != 0 || stall_cnt !== 8'd0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_end: got missing=%0d stall=%0d busy=%b want 0 0 0", name, exp_q.size(), stall_cnt, busy);
    end
    exp_q.delete();
  endtask

  task automatic test_stall();
    wr_t w;
    int  done_cyc = -1;
    push_fill(15'h0010, 4, 16'h0038, 1'b1, 2, 2);
    cpu_addr = 15'h0777; cpu_wdata = 16'hAAAA; cpu_we_l = 1'b0; cpu_we_h = 1'b0;
    launch(15'h0010, 16'd4, 16'h0038, 1'b1);
    for (int c = 1; c <= 10; c++) begin
      cpu_req = (c == 2 || c == 3);
      @(negedge e);
      if (dat_we_l || dat_we_h) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL stall_extra_write: got addr=%h cyc=%0d want none", dat_addr, c);
        end else begin
          w = exp_q.pop_front();
          if (dat_addr !== w.a || dat_wdata !== w.d || c != w.c) begin
            failures++;
            $display("FAIL stall_write: got addr=%h data=%h cyc=%0d want addr=%h data=%h cyc=%0d",
                     dat_addr, dat_wdata, c, w.a, w.d, w.c);
          end
        end
      end
      if (cpu_req) begin
        checks++;
        if (dat_addr !== 15'h0777 || dat_wdata !== 16'hAAAA || busy !== 1'b1) begin
          failures++;
          $display("FAIL stall_passthru: got addr=%h data=%h busy=%b want 0777 aaaa 1", dat_addr, dat_wdata, busy);
        end
      end
      if (done && done_cyc < 0) done_cyc = c;
      @(posedge e);
      #1;
    end
    cpu_req = 1'b0;
    checks++;
    if (done_cyc != 8 || stall_cnt !== 8'd2 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL stall_done: got cyc=%0d stall=%0d missing=%0d want 8 2 0", done_cyc, stall_cnt, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_saturate();
    wr_t w;
    int  done_cyc = -1;
    push_fill(15'h0020, 1, 16'h0005, 1'b0, 1, 300);
    launch(15'h0020, 16'd1, 16'h0005, 1'b0);
    for (int c = 1; c <= 306; c++) begin
      cpu_req = (c <= 300);
      @(negedge e);
      if (dat_we_l || dat_we_h) begin
        checks++;
        w = exp_q.pop_front();
        if (dat_addr !== w.a || dat_wdata !== w.d || c != w.c) begin
          failures++;
          $display("FAIL sat_write: got addr=%h data=%h cyc=%0d want addr=%h data=%h cyc=%0d",
                   dat_addr, dat_wdata, c, w.a, w.d, w.c);
        end
      end
      if (done && done_cyc < 0) done_cyc = c;
      @(posedge e);
      #1;
    end
    cpu_req = 1'b0;
    checks++;
    if (done_cyc != 303 || stall_cnt !== 8'd255 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL sat_done: got cyc=%0d stall=%0d missing=%0d want 303 255 0", done_cyc, stall_cnt, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_zero();
    int done_cyc = -1;
    int nwe = 0;
    int nbusy = 0;
    launch(15'h0050, 16'd0, 16'h1111, 1'b1);
    for (int c = 1; c <= 6; c++) begin
      @(negedge e);
      if (dat_we_l || dat_we_h) nwe++;
      if (busy) nbusy++;
      if (done && done_cyc < 0) done_cyc = c;
      @(posedge e);
      #1;
    end
    checks++;
    if (done_cyc != 2 || nwe != 0 || nbusy != 0) begin
      failures++;
      $display("FAIL zero_count: got done_cyc=%0d writes=%0d busy_cycles=%0d want 2 0 0", done_cyc, nwe, nbusy);
    end
  endtask

  task automatic test_busy_start();
    wr_t w;
    int  done_cyc = -1;
    int  ndone = 0;
    push_fill(15'h0300, 4, 16'h0010, 1'b1, 1 << 20, 0);
    launch(15'h0300, 16'd4, 16'h0010, 1'b1);
    for (int c = 1; c <= 9; c++) begin
      if (c == 2) begin
        start = 1'b1; start_addr = 15'h0400; count = 16'd2; fill_val = 16'h0099; fill_inc = 1'b0;
      end else begin
        start = 1'b0;
      end
      @(negedge e);
      if (dat_we_l || dat_we_h) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL busy_start_extra_write: got addr=%h data=%h cyc=%0d want none", dat_addr, dat_wdata, c);
        end else begin
          w = exp_q.pop_front();
          if (dat_addr !== w.a || dat_wdata !== w.d || c != w.c) begin
            failures++;
            $display("FAIL busy_start_write: got addr=%h data=%h cyc=%0d want addr=%h data=%h cyc=%0d",
                     dat_addr, dat_wdata, c, w.a, w.d, w.c);
          end
        end
      end
      if (done) begin
        ndone++;
        if (done_cyc < 0) done_cyc = c;
      end
      @(posedge e);
      #1;
    end
    checks++;
    if (done_cyc != 6 || ndone != 1 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL busy_start_done: got cyc=%0d pulses=%0d missing=%0d want 6 1 0", done_cyc, ndone, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset_abort();
    wr_t w;
    int  nwe = 0;
    int  ndone = 0;
    push_fill(15'h0200, 8, 16'h0040, 1'b1, 1 << 20, 0);
    launch(15'h0200, 16'd8, 16'h0040, 1'b1);
    for (int c = 1; c <= 2; c++) begin
      @(negedge e);
      checks++;
      w = exp_q.pop_front();
      if (dat_we_l !== 1'b1 || dat_addr !== w.a || dat_wdata !== w.d) begin
        failures++;
        $display("FAIL abort_pre_write: got we=%b addr=%h data=%h want 1 %h %h", dat_we_l, dat_addr, dat_wdata, w.a, w.d);
      end
      @(posedge e);
      #1;
    end
    checks++;
    if (dat_we_l !== 1'b1 || dat_addr !== 15'h0202) begin
      failures++;
      $display("FAIL abort_third_write: got we=%b addr=%h want 1 0202", dat_we_l, dat_addr);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (dat_we_l !== 1'b0 || dat_we_h !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_drop: got we=%b%b busy=%b want 00 0", dat_we_h, dat_we_l, busy);
    end
    exp_q.delete();
    repeat (2) @(negedge e);
    reset = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge e);
      if (dat_we_l || dat_we_h) nwe++;
      if (done) ndone++;
    end
    checks++;
    if (nwe != 0 || ndone != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_after: got writes=%0d done_pulses=%0d busy=%b want 0 0 0", nwe, ndone, busy);
    end
  endtask

  initial begin
    test_reset();
    test_uncontested("basic", 15'h0010, 4, 16'h0038, 1'b1);
    test_stall();
    test_saturate();
    test_uncontested("wrap", 15'h7FFE, 3, 16'hFFFF, 1'b1);
    test_uncontested("const", 15'h0100, 3, 16'h1234, 1'b0);
    test_zero();
    test_busy_start();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
